simplex_iter_ctrl: RTL and testbench
====================================

# simplex_iter_ctrl

Top-level sequencer for the simplex solver datapath. On `start` it repeatedly runs the pivot-column search, the pivot-row ratio test and the tableau pivot update, one after another, until one of three things happens: no pivot column exists (optimal), no pivot row exists (unbounded), or the iteration budget runs out. It owns the start/done handshakes of the three engines, latches the chosen pivot coordinates for the update engine, and reports termination status to the host interface.

## Interface
- `COL_W`, 16, width of column indices
- `ROW_W`, 16, width of row indices
- `ITER_W`, 16, width of the iteration counter
- `MAX_ITER`, 1000, iteration budget (number of completed pivots); must satisfy 0 < `MAX_ITER` < 2^`ITER_W`
- `clk`  in  1  sole clock, rising edge
- `aresetn`  in  1  asynchronous, active-low reset
- `start`  in  1  request a solve; accepted only in IDLE or DONE
- `col_start`  out  1  one-cycle pulse that launches the column search
- `col_done`  in  1  column search finished (level)
- `col_found`  in  1  a negative last-row entry exists; valid with `col_done`
- `col_idx`  in  COL_W  pivot column; valid with `col_done`
- `row_start`  out  1  one-cycle pulse that launches the ratio test
- `row_done`  in  1  ratio test finished (level)
- `row_found`  in  1  a positive-denominator row exists; valid with `row_done`
- `row_idx`  in  ROW_W  pivot row; valid with `row_done`
- `piv_start`  out  1  one-cycle pulse that launches the tableau update
- `piv_done`  in  1  tableau update finished (level)
- `pivot_col`  out  COL_W  latched pivot column, driven to the row and pivot engines
- `pivot_row`  out  ROW_W  latched pivot row, driven to the pivot engine
- `busy`  out  1  high in every state except IDLE and DONE
- `done`  out  1  high while in DONE
- `status`  out  2  0 = none, 1 = optimal, 2 = unbounded, 3 = iteration limit
- `iter_count`  out  ITER_W  number of pivots completed in the current solve

## Operation
- States: IDLE, CHK, COL_ISSUE, COL_WAIT, ROW_ISSUE, ROW_WAIT, PIV_ISSUE, PIV_WAIT, DONE.
- IDLE: on `start`, clear `iter_count`, `status`, `pivot_col` and `pivot_row` to 0, then go to CHK.
- CHK: if `iter_count` == `MAX_ITER`, set `status` = 3 and go to DONE. Otherwise go to COL_ISSUE.
- COL_ISSUE: assert `col_start` for exactly this one cycle, then go to COL_WAIT.
- COL_WAIT: when `col_done` is high:
  - `col_found` = 0: set `status` = 1, go to DONE.
  - `col_found` = 1: latch `col_idx` into `pivot_col`, go to ROW_ISSUE.
- ROW_ISSUE: `row_start` pulse, then go to ROW_WAIT.
- ROW_WAIT: when `row_done` is high:
  - `row_found` = 0: set `status` = 2, go to DONE.
  - `row_found` = 1: latch `row_idx` into `pivot_row`, go to PIV_ISSUE.
- PIV_ISSUE: `piv_start` pulse, then go to PIV_WAIT.
- PIV_WAIT: when `piv_done` is high, increment `iter_count` and go to CHK.
- DONE: hold `status`, `iter_count`, `pivot_col` and `pivot_row`. A new `start` behaves exactly as `start` in IDLE.
- The `*_done`, `*_found` and `*_idx` inputs are sampled only in their own WAIT state and ignored everywhere else. This means a stale level-high done left over from the previous launch never advances the FSM.
- `start` is ignored while `busy` is high. There is no abort; `aresetn` is the only way to stop a solve.
- `iter_count` never wraps, because CHK stops at `MAX_ITER`.
- `pivot_col` and `pivot_row` stay stable from their latch until the next latch or the next `start`.

## Timing
- Reset (`aresetn` low, asynchronous): state = IDLE; all outputs 0 (`busy`, `done`, `status`, `iter_count`, `pivot_col`, `pivot_row`, and every `*_start`). Reset mid-solve aborts immediately; the engines are reset by the same `aresetn`.
- Every state transition is registered, and all outputs are registered (Moore).
- `start` sampled at edge N: `busy` goes high at N+1 (state CHK), `col_start` is high during N+2 → N+3.
- A done input sampled high at edge M in its WAIT state: the next `*_start` is high from M+1 to M+2, or `done` is high from M+1.
- Minimum controller overhead per iteration: 7 cycles (CHK, three ISSUE states, and one cycle in each of the three WAIT states). Total iteration time is this plus the engine latencies.
- `done` and `status` change in the same cycle. `iter_count` updates in the cycle after the `piv_done` edge.

## Test plan
- Immediate optimal: `start`; engine model returns `col_done` = 1, `col_found` = 0 → `status` = 1, `iter_count` = 0, exactly one `col_start` and no `row_start`.
- Two pivots then optimal: columns 5 then 2, rows 3 then 7, third column search not found → `status` = 1, `iter_count` = 2, `pivot_col` = 2, `pivot_row` = 7, and `piv_start` observed exactly twice with coordinates (3,5) then (7,2).
- Unbounded: column 9 found, `row_found` = 0 → `status` = 2, `pivot_col` = 9, no `piv_start`.
- Iteration limit: `MAX_ITER` = 3 with engines that always find a pivot → `status` = 3, `iter_count` = 3, `col_start` issued exactly 3 times.
- Stale done / ignored start: hold `col_done` high permanently and pulse `start` while `busy` → the FSM waits for its own COL_WAIT before consuming `col_done`, the second `start` has no effect, and `busy` never drops early.
- Reset mid-solve: deassert `aresetn` (drive low) during PIV_WAIT → all outputs read 0 within the same cycle; after release, a fresh `start` runs normally with `iter_count` restarting at 0.

Source files
------------

// File: rtl/simplex_iter_ctrl.sv
`timescale 1ns/1ps
// simplex_iter_ctrl
// Top-level sequencer for the simplex solver datapath. A solve repeatedly
// runs column search -> ratio test -> pivot update until the solver is
// optimal, the problem is unbounded, or MAX_ITER pivots have completed.
//
// Engine handshake: each engine is launched by a one-cycle *_start pulse
// and answers with a level *_done (plus *_found / *_idx qualified by it).
// The controller only samples an engine's done/found/idx while sitting in
// that engine's WAIT state, so a done level left high from an earlier
// launch can never advance the sequence. All outputs come from flops.
module simplex_iter_ctrl #(
    parameter int COL_W    = 16,
    parameter int ROW_W    = 16,
    parameter int ITER_W   = 16,
    parameter int MAX_ITER = 1000
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              start,
    output logic              col_start,
    input  logic              col_done,
    input  logic              col_found,
    input  logic [COL_W-1:0]  col_idx,
    output logic              row_start,
    input  logic              row_done,
    input  logic              row_found,
    input  logic [ROW_W-1:0]  row_idx,
    output logic              piv_start,
    input  logic              piv_done,
    output logic [COL_W-1:0]  pivot_col,
    output logic [ROW_W-1:0]  pivot_row,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [ITER_W-1:0] iter_count,
    output logic [3:0]        dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CHK       = 4'd1,
        S_COL_ISSUE = 4'd2,
        S_COL_WAIT  = 4'd3,
        S_ROW_ISSUE = 4'd4,
        S_ROW_WAIT  = 4'd5,
        S_PIV_ISSUE = 4'd6,
        S_PIV_WAIT  = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    localparam logic [ITER_W-1:0] LP_MAX_ITER = ITER_W'(MAX_ITER);
    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_OPTIMAL = 2'd1;
    localparam logic [1:0] ST_UNBOUND = 2'd2;
    localparam logic [1:0] ST_LIMIT   = 2'd3;

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          r_status;
    logic [1:0]          w_next_status;
    logic [ITER_W-1:0]   r_iter;
    logic [ITER_W-1:0]   w_next_iter;
    logic [COL_W-1:0]    r_pivot_col;
    logic [COL_W-1:0]    w_next_pivot_col;
    logic [ROW_W-1:0]    r_pivot_row;
    logic [ROW_W-1:0]    w_next_pivot_row;
    logic                r_col_start;
    logic                r_row_start;
    logic                r_piv_start;
    logic                r_busy;
    logic                r_done;

    // Next-state and next-context decode; every target defaults to hold.
    always_comb begin
        w_next_state     = r_state;
        w_next_status    = r_status;
        w_next_iter      = r_iter;
        w_next_pivot_col = r_pivot_col;
        w_next_pivot_row = r_pivot_row;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next_state     = S_CHK;
                    w_next_status    = ST_NONE;
                    w_next_iter      = '0;
                    w_next_pivot_col = '0;
                    w_next_pivot_row = '0;
                end
            end
            S_CHK: begin
                if (r_iter == LP_MAX_ITER) begin
                    w_next_status = ST_LIMIT;
                    w_next_state  = S_DONE;
                end else begin
                    w_next_state = S_COL_ISSUE;
                end
            end
            S_COL_ISSUE: w_next_state = S_COL_WAIT;
            S_COL_WAIT: begin
                if (col_done) begin
                    if (col_found) begin
                        w_next_pivot_col = col_idx;
                        w_next_state     = S_ROW_ISSUE;
                    end else begin
                        w_next_status = ST_OPTIMAL;
                        w_next_state  = S_DONE;
                    end
                end
            end
            S_ROW_ISSUE: w_next_state = S_ROW_WAIT;
            S_ROW_WAIT: begin
                if (row_done) begin
                    if (row_found) begin
                        w_next_pivot_row = row_idx;
                        w_next_state     = S_PIV_ISSUE;
                    end else begin
                        w_next_status = ST_UNBOUND;
                        w_next_state  = S_DONE;
                    end
                end
            end
            S_PIV_ISSUE: w_next_state = S_PIV_WAIT;
            S_PIV_WAIT: begin
                if (piv_done) begin
                    w_next_iter  = r_iter + ITER_W'(1);
                    w_next_state = S_CHK;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State and solve context registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_status    <= ST_NONE;
            r_iter      <= '0;
            r_pivot_col <= '0;
            r_pivot_row <= '0;
        end else begin
            r_state     <= w_next_state;
            r_status    <= w_next_status;
            r_iter      <= w_next_iter;
            r_pivot_col <= w_next_pivot_col;
            r_pivot_row <= w_next_pivot_row;
        end
    end

    // Moore flags registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_col_start <= 1'b0;
            r_row_start <= 1'b0;
            r_piv_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_col_start <= (w_next_state == S_COL_ISSUE);
            r_row_start <= (w_next_state == S_ROW_ISSUE);
            r_piv_start <= (w_next_state == S_PIV_ISSUE);
            r_busy      <= (w_next_state != S_IDLE) && (w_next_state != S_DONE);
            r_done      <= (w_next_state == S_DONE);
        end
    end

    assign col_start  = r_col_start;
    assign row_start  = r_row_start;
    assign piv_start  = r_piv_start;
    assign busy       = r_busy;
    assign done       = r_done;
    assign status     = r_status;
    assign iter_count = r_iter;
    assign pivot_col  = r_pivot_col;
    assign pivot_row  = r_pivot_row;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_simplex_iter_ctrl.sv
`timescale 1ns/1ps
// Bench for simplex_iter_ctrl: engine model driven from per-solve response
// tables, scoreboard of expected solve outcomes and pivot coordinates.
module tb_simplex_iter_ctrl;

    typedef struct packed {
        logic [1:0]  status;
        logic [15:0] iter;
        logic [15:0] pc;
        logic [15:0] pr;
        logic [7:0]  nc;
        logic [7:0]  nr;
        logic [7:0]  np;
    } exp_t;

    // Clock / reset / DUT signals
    logic        clk = 1'b0;
    logic        aresetn;
    logic        start;
    logic        col_start, row_start, piv_start;
    logic        col_done, col_found;
    logic [15:0] col_idx;
    logic        row_done, row_found;
    logic [15:0] row_idx;
    logic        piv_done;
    logic [15:0] pivot_col, pivot_row;
    logic        busy, done;
    logic [1:0]  status;
    logic [15:0] iter_count;
    logic [3:0]  dbg_state;

    // Engine model configuration
    logic        col_found_tab [8];
    logic [15:0] col_idx_tab   [8];
    logic        row_found_tab [8];
    logic [15:0] row_idx_tab   [8];
    int          col_lat, row_lat, piv_lat;
    logic        col_force;
    int          col_calls, row_calls, piv_calls;
    int          col_sel, row_sel;
    int          col_cd, row_cd, piv_cd;

    // Scoreboard
    exp_t        exp_q[$];
    logic [31:0] piv_exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic        prev_done = 1'b0;

    always #5 clk = ~clk;

    simplex_iter_ctrl #(
        .COL_W(16), .ROW_W(16), .ITER_W(16), .MAX_ITER(3)
    ) dut (
        .clk(clk), .aresetn(aresetn), .start(start),
        .col_start(col_start), .col_done(col_done), .col_found(col_found), .col_idx(col_idx),
        .row_start(row_start), .row_done(row_done), .row_found(row_found), .row_idx(row_idx),
        .piv_start(piv_start), .piv_done(piv_done),
        .pivot_col(pivot_col), .pivot_row(pivot_row),
        .busy(busy), .done(done), .status(status), .iter_count(iter_count),
        .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int st, input int it, input int pc, input int pr,
                            input int nc, input int nr, input int np);
        exp_t e;
        e.status = st[1:0];
        e.iter   = it[15:0];
        e.pc     = pc[15:0];
        e.pr     = pr[15:0];
        e.nc     = nc[7:0];
        e.nr     = nr[7:0];
        e.np     = np[7:0];
        exp_q.push_back(e);
    endtask

    task automatic push_piv(input int row, input int col);
        piv_exp_q.push_back({row[15:0], col[15:0]});
    endtask

    // Driver: one start pulse; returns just after the edge that accepted it.
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    endtask

    // Engine model: level done, cleared by a new launch, raised after latency.
    always @(negedge clk) begin
        if (!aresetn) begin
            col_done = 1'b0; row_done = 1'b0; piv_done = 1'b0;
            col_cd = 0; row_cd = 0; piv_cd = 0;
        end else begin
            if (start && !busy) begin
                col_calls = 0; row_calls = 0; piv_calls = 0;
            end
            if (col_start) begin
                col_done = 1'b0; col_sel = col_calls & 7; col_calls++; col_cd = col_lat;
            end else if (col_cd > 0) begin
                col_cd--;
                if (col_cd == 0) begin
                    col_done  = 1'b1;
                    col_found = col_found_tab[col_sel];
                    col_idx   = col_idx_tab[col_sel];
                end
            end
            if (row_start) begin
                row_done = 1'b0; row_sel = row_calls & 7; row_calls++; row_cd = row_lat;
            end else if (row_cd > 0) begin
                row_cd--;
                if (row_cd == 0) begin
                    row_done  = 1'b1;
                    row_found = row_found_tab[row_sel];
                    row_idx   = row_idx_tab[row_sel];
                end
            end
            if (piv_start) begin
                piv_done = 1'b0; piv_calls++; piv_cd = piv_lat;
            end else if (piv_cd > 0) begin
                piv_cd--;
                if (piv_cd == 0) piv_done = 1'b1;
            end
            if (col_force) begin
                col_done  = 1'b1;
                col_found = 1'b0;
            end
        end
    end

    // Monitor: compare solve outcome on each rising done, pivot coords on each piv_start.
    always @(negedge clk) begin
        exp_t e;
        if (piv_start) begin
            check("piv_expected", {31'd0, piv_exp_q.size() > 0}, 32'd1);
            if (piv_exp_q.size() > 0) begin
                logic [31:0] p;
                p = piv_exp_q.pop_front();
                check("piv_row", {16'd0, pivot_row}, {16'd0, p[31:16]});
                check("piv_col", {16'd0, pivot_col}, {16'd0, p[15:0]});
            end
        end
        if (done && !prev_done) begin
            check("solve_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("status",     {30'd0, status},     {30'd0, e.status});
                check("iter_count", {16'd0, iter_count}, {16'd0, e.iter});
                check("pivot_col",  {16'd0, pivot_col},  {16'd0, e.pc});
                check("pivot_row",  {16'd0, pivot_row},  {16'd0, e.pr});
                check("n_col_start", col_calls, {24'd0, e.nc});
                check("n_row_start", row_calls, {24'd0, e.nr});
                check("n_piv_start", piv_calls, {24'd0, e.np});
            end
        end
        prev_done = done;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic seen;
        aresetn = 1'b0; start = 1'b0; col_force = 1'b0;
        col_done = 1'b0; col_found = 1'b0; col_idx = '0;
        row_done = 1'b0; row_found = 1'b0; row_idx = '0; piv_done = 1'b0;
        col_lat = 2; row_lat = 3; piv_lat = 4;
        col_calls = 0; row_calls = 0; piv_calls = 0;
        col_sel = 0; row_sel = 0; col_cd = 0; row_cd = 0; piv_cd = 0;
        for (int i = 0; i < 8; i++) begin
            col_found_tab[i] = 1'b0; col_idx_tab[i] = '0;
            row_found_tab[i] = 1'b0; row_idx_tab[i] = '0;
        end

        // Reset state
        #3;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_status", {30'd0, status}, 32'd0);
        check("rst_iter", {16'd0, iter_count}, 32'd0);
        check("rst_starts", {29'd0, col_start, row_start, piv_start}, 32'd0);
        check("rst_state", {28'd0, dbg_state}, 32'd0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;

        // Immediate optimal, with launch timing
        col_found_tab[0] = 1'b0;
        push_exp(1, 0, 0, 0, 1, 0, 0);
        pulse_start();
        @(negedge clk);
        check("t1_chk_busy", {31'd0, busy}, 32'd1);
        check("t1_chk_col_start", {31'd0, col_start}, 32'd0);
        @(negedge clk);
        check("t1_issue_col_start", {31'd0, col_start}, 32'd1);
        wait_done("t1");

        // Two pivots then optimal
        col_found_tab[0] = 1'b1; col_idx_tab[0] = 16'd5;
        col_found_tab[1] = 1'b1; col_idx_tab[1] = 16'd2;
        col_found_tab[2] = 1'b0; col_idx_tab[2] = 16'd0;
        row_found_tab[0] = 1'b1; row_idx_tab[0] = 16'd3;
        row_found_tab[1] = 1'b1; row_idx_tab[1] = 16'd7;
        push_piv(3, 5);
        push_piv(7, 2);
        push_exp(1, 2, 2, 7, 3, 2, 2);
        pulse_start();
        wait_done("t2");

        // Unbounded
        col_found_tab[0] = 1'b1; col_idx_tab[0] = 16'd9;
        row_found_tab[0] = 1'b0; row_idx_tab[0] = 16'd4;
        push_exp(2, 0, 9, 0, 1, 1, 0);
        pulse_start();
        wait_done("t3");

        // Iteration limit (MAX_ITER = 3)
        for (int i = 0; i < 4; i++) begin
            col_found_tab[i] = 1'b1; col_idx_tab[i] = 16'(10 + i);
            row_found_tab[i] = 1'b1; row_idx_tab[i] = 16'(20 + i);
        end
        push_piv(20, 10);
        push_piv(21, 11);
        push_piv(22, 12);
        push_exp(3, 3, 12, 22, 3, 3, 3);
        pulse_start();
        wait_done("t4");

        // Stale level-high col_done plus start while busy
        col_force = 1'b1;
        push_exp(1, 0, 0, 0, 1, 0, 0);
        pulse_start();
        @(negedge clk);
        check("t5_chk_busy", {31'd0, busy}, 32'd1);
        check("t5_chk_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk);
        check("t5_issue_col_start", {31'd0, col_start}, 32'd1);
        check("t5_issue_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("t5_wait_busy", {31'd0, busy}, 32'd1);
        check("t5_wait_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("t5_done_now", {31'd0, done}, 32'd1);
        check("t5_busy_low", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("t5_done_hold", {31'd0, done}, 32'd1);
        check("t5_state_done", {28'd0, dbg_state}, 32'd8);
        col_force = 1'b0;

        // Reset during PIV_WAIT
        col_found_tab[0] = 1'b1; col_idx_tab[0] = 16'd4;
        row_found_tab[0] = 1'b1; row_idx_tab[0] = 16'd6;
        piv_lat = 40;
        push_piv(6, 4);
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (piv_start) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_piv_start_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        check("t6_in_piv_wait", {28'd0, dbg_state}, 32'd7);
        #2 aresetn = 1'b0;
        #1;
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_done", {31'd0, done}, 32'd0);
        check("t6_rst_status", {30'd0, status}, 32'd0);
        check("t6_rst_iter", {16'd0, iter_count}, 32'd0);
        check("t6_rst_pivot_col", {16'd0, pivot_col}, 32'd0);
        check("t6_rst_pivot_row", {16'd0, pivot_row}, 32'd0);
        check("t6_rst_starts", {29'd0, col_start, row_start, piv_start}, 32'd0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        piv_lat = 4;

        // Fresh solve after reset: one pivot, then optimal
        col_found_tab[0] = 1'b1; col_idx_tab[0] = 16'd1;
        col_found_tab[1] = 1'b0;
        row_found_tab[0] = 1'b1; row_idx_tab[0] = 16'd8;
        push_piv(8, 1);
        push_exp(1, 1, 1, 8, 2, 1, 1);
        pulse_start();
        wait_done("t7");

        repeat (3) @(negedge clk);
        check("sb_solve_drained", exp_q.size(), 32'd0);
        check("sb_piv_drained", piv_exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
